imem_loader: RTL and testbench

Write-side counterpart of the VR16 instruction memory. Receives a framed byte stream (count, 16-bit instruction words as byte pairs, XOR checksum) over a valid/ready byte interface, typically from a UART receiver. It assembles the bytes into words and drives the instruction memory write port with auto-incrementing addresses. While a load is in progress it holds the core off via `busy`.

---
 rtl/vr16_pkg.sv | 16 +
 rtl/imem_checksum.sv | 25 ++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vr16_pkg.sv
// Shared VR16 definitions: instruction memory geometry and the state
// encoding used by the instruction memory loader.
package vr16_pkg;

   localparam int IMEM_ADDR_WIDTH = 8;
   localparam int INSTR_WIDTH     = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_CHECK = 3'd4
   } loader_state_t;

endpackage

// File: rtl/imem_checksum.sv
// Running 8-bit XOR over the payload bytes of a load frame.
module imem_checksum
   import vr16_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] data_in,
   output logic [7:0] sum
);

   // Accumulate the XOR of each enabled byte; clear wins so a new session
   // always starts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (enable) begin
         sum <= sum ^ data_in;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Frame-based instruction memory loader: COUNT, N big-endian words, XOR
// checksum. Writes words to auto-incrementing addresses and holds the core
// off through busy while a session is open.
module imem_loader
   import vr16_pkg::*;
#(
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = INSTR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   // Remaining-word counter needs one extra bit so a COUNT of zero can
   // stand for the full memory depth.
   localparam int REM_W = ADDR_WIDTH + 1;

   loader_state_t state;
   loader_state_t state_next;

   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [REM_W-1:0]      remaining;
   logic [7:0]            hi_byte;
   logic [7:0]            chk_sum;

   logic accept;
   logic open_session;
   logic load_count;
   logic latch_hi;
   logic sum_en;
   logic do_write;
   logic do_done;
   logic set_err;

   // The loader is always willing to take a byte once a session is open,
   // so the sender is never stalled; busy mirrors the same condition.
   assign rx_ready = (state != ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign accept   = rx_valid && rx_ready;

   // Checksum covers payload bytes only; it is cleared when a session opens.
   imem_checksum u_checksum (
      .clk     (clk),
      .reset   (reset),
      .clear   (open_session),
      .enable  (sum_en),
      .data_in (rx_data),
      .sum     (chk_sum)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode; abort takes priority over a byte
   // arriving on the same edge so nothing new is written after an abort.
   always_comb begin
      state_next   = state;
      open_session = 1'b0;
      load_count   = 1'b0;
      latch_hi     = 1'b0;
      sum_en       = 1'b0;
      do_write     = 1'b0;
      do_done      = 1'b0;
      set_err      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               open_session = 1'b1;
               state_next   = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (abort) begin
               set_err    = 1'b1;
               state_next = ST_IDLE;
            end else if (accept) begin
               load_count = 1'b1;
               state_next = ST_HI;
            end
         end
         ST_HI: begin
            if (abort) begin
               set_err    = 1'b1;
               state_next = ST_IDLE;
            end else if (accept) begin
               latch_hi   = 1'b1;
               sum_en     = 1'b1;
               state_next = ST_LO;
            end
         end
         ST_LO: begin
            if (abort) begin
               set_err    = 1'b1;
               state_next = ST_IDLE;
            end else if (accept) begin
               sum_en     = 1'b1;
               do_write   = 1'b1;
               state_next = (remaining == REM_W'(1)) ? ST_CHECK : ST_HI;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               set_err    = 1'b1;
               state_next = ST_IDLE;
            end else if (accept) begin
               do_done    = 1'b1;
               set_err    = (rx_data != chk_sum);
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: counters, high-byte holding register and the registered
   // memory write port. Address and data hold their values between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_cnt  <= '0;
         remaining <= '0;
         hi_byte   <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_en <= do_write;
         done  <= do_done;
         if (open_session) begin
            addr_cnt <= '0;
            error    <= 1'b0;
         end else if (set_err) begin
            error <= 1'b1;
         end
         if (load_count) begin
            remaining <= (rx_data == 8'h00) ? REM_W'(1 << ADDR_WIDTH) : REM_W'(rx_data);
         end
         if (latch_hi) begin
            hi_byte <= rx_data;
         end
         if (do_write) begin
            wr_addr   <= addr_cnt;
            wr_data   <= DATA_WIDTH'({hi_byte, rx_data});
            addr_cnt  <= addr_cnt + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, hand-written
// control corner cases and randomized frames against a frame-level model.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;

   int total;
   int bad;

   logic [15:0] payload[$];
   logic [23:0] gotWrites[$];
   int          doneCount;
   int          wideCount;
   logic        prevWr;

   typedef struct {
      logic [7:0]  count;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0]  chk;
      int          gapMax;
      bit          expErr;
   } vec_t;

   vec_t vecs[4];

   imem_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe the write port and done on the falling edge, away from the
   // active edge; also flag any write strobe lasting more than one cycle.
   always @(negedge clk) begin
      if (wr_en) gotWrites.push_back({wr_addr, wr_data});
      if (done) doneCount++;
      if (wr_en && prevWr) wideCount++;
      prevWr = wr_en;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Present one byte for a single edge, then idle for gap cycles.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = $urandom();
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Reference model: XOR of every payload byte of the frame.
   function automatic logic [7:0] frameXor();
      logic [7:0] x;
      x = 8'h00;
      foreach (payload[i]) x = x ^ payload[i][15:8] ^ payload[i][7:0];
      return x;
   endfunction

   // Run one complete session using the words in payload; writes are
   // expected at addresses 0..N-1 in order, with one done pulse.
   task automatic runFrame(input logic [7:0] cnt, input logic [7:0] chk, input bit expErr,
                           input int gapMax, input bit midStart, input string tag);
      int n;
      n = (cnt == 8'h00) ? 256 : int'(cnt);
      gotWrites.delete();
      doneCount = 0;
      wideCount = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput({tag, "_busy_on_start"}, busy, 1);
      checkOutput({tag, "_ready_on_start"}, rx_ready, 1);
      checkOutput({tag, "_error_cleared"}, error, 0);
      applyStimulus(cnt, $urandom_range(gapMax, 0));
      if (midStart) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         applyStimulus(payload[i][15:8], $urandom_range(gapMax, 0));
         applyStimulus(payload[i][7:0], $urandom_range(gapMax, 0));
      end
      applyStimulus(chk, 0);
      checkOutput({tag, "_done_pulse"}, done, 1);
      checkOutput({tag, "_busy_in_done"}, busy, 0);
      checkOutput({tag, "_ready_in_done"}, rx_ready, 0);
      checkOutput({tag, "_error_at_done"}, error, expErr);
      @(posedge clk); #1;
      checkOutput({tag, "_done_one_cycle"}, done, 0);
      @(posedge clk); #1;
      checkOutput({tag, "_done_count"}, doneCount, 1);
      checkOutput({tag, "_write_count"}, gotWrites.size(), n);
      checkOutput({tag, "_wide_write"}, wideCount, 0);
      checkOutput({tag, "_error_sticky"}, error, expErr);
      for (int i = 0; i < n && i < gotWrites.size(); i++) begin
         checkOutput({tag, "_write"}, gotWrites[i], {i[7:0], payload[i]});
      end
   endtask

   initial begin
      logic [7:0] c;
      logic [7:0] k;
      int         n;
      total    = 0;
      bad      = 0;
      prevWr   = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      reset    = 1'b0;
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ready", rx_ready, 0);
      checkOutput("reset_wr_en", wr_en, 0);
      checkOutput("reset_wr_addr", wr_addr, 0);
      checkOutput("reset_wr_data", wr_data, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_error", error, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      vecs[0] = '{count: 8'h02, w0: 16'h1234, w1: 16'hABCD, chk: 8'h40, gapMax: 0, expErr: 1'b0};
      vecs[1] = '{count: 8'h02, w0: 16'h1234, w1: 16'hABCD, chk: 8'h41, gapMax: 0, expErr: 1'b1};
      vecs[2] = '{count: 8'h02, w0: 16'h1234, w1: 16'hABCD, chk: 8'h40, gapMax: 5, expErr: 1'b0};
      vecs[3] = '{count: 8'h01, w0: 16'h00FF, w1: 16'h0000, chk: 8'hFF, gapMax: 2, expErr: 1'b0};

      foreach (vecs[v]) begin
         payload.delete();
         payload.push_back(vecs[v].w0);
         if (vecs[v].count == 8'h02) payload.push_back(vecs[v].w1);
         runFrame(vecs[v].count, vecs[v].chk, vecs[v].expErr, vecs[v].gapMax, 1'b0, $sformatf("vec%0d", v));
      end

      // start while a session is open must not restart it
      payload.delete();
      payload.push_back(16'h1234);
      payload.push_back(16'hABCD);
      runFrame(8'h02, 8'h40, 1'b0, 0, 1'b1, "start_busy");

      // abort after the first word: only address 0 written, no done
      gotWrites.delete();
      doneCount = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      applyStimulus(8'h02, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_error", error, 1);
      checkOutput("abort_done", done, 0);
      applyStimulus(8'hAB, 0);
      applyStimulus(8'hCD, 0);
      applyStimulus(8'h40, 0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      checkOutput("abort_write_count", gotWrites.size(), 1);
      if (gotWrites.size() > 0) checkOutput("abort_write0", gotWrites[0], {8'h00, 16'h1234});
      checkOutput("abort_done_count", doneCount, 0);
      checkOutput("abort_error_sticky", error, 1);

      // reset in the middle of a frame clears everything immediately
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      applyStimulus(8'h02, 0);
      applyStimulus(8'h12, 0);
      #2 reset = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_ready", rx_ready, 0);
      checkOutput("midrst_wr_addr", wr_addr, 0);
      checkOutput("midrst_wr_data", wr_data, 0);
      checkOutput("midrst_error", error, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      payload.delete();
      payload.push_back(16'h1234);
      payload.push_back(16'hABCD);
      runFrame(8'h02, 8'h40, 1'b0, 0, 1'b0, "after_reset");

      // full depth: 256 words of value = index, last write at 0xFF
      payload.delete();
      for (int i = 0; i < 256; i++) payload.push_back(16'(i));
      runFrame(8'h00, frameXor(), 1'b0, 0, 1'b0, "full");
      if (gotWrites.size() == 256) checkOutput("full_last_addr", gotWrites[255][23:16], 8'hFF);

      payload.delete();
      payload.push_back(16'h1234);
      payload.push_back(16'hABCD);
      runFrame(8'h02, 8'h40, 1'b0, 0, 1'b0, "after_full");

      // randomized frames against the frame-level model
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(8, 1);
         payload.delete();
         for (int i = 0; i < n; i++) payload.push_back(16'($urandom()));
         k = 8'h00;
         if ($urandom_range(1, 0) == 1) k = 8'($urandom_range(255, 1));
         c = frameXor() ^ k;
         runFrame(8'(n), c, (c != frameXor()), $urandom_range(3, 0), 1'b0, $sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
